// File: rtl/ring_counter.sv
// ring_counter: one-hot ring counter with serial seed load into bit 0, rotating left every clock.
// Optional macro RING_COUNTER_SELFCORRECT_EN: a multi-hot ring is reseeded to one-hot bit 0 on a rotate edge.
`default_nettype none

module ring_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ring_q;
    logic [WIDTH-1:0] ring_d;
    logic [WIDTH-1:0] rotated;
    logic [WIDTH-1:0] seed;

    assign rotated = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    assign seed    = {{(WIDTH-1){1'b0}}, in};

`ifdef RING_COUNTER_SELFCORRECT_EN
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    logic multi_hot;
    assign multi_hot = |(ring_q & (ring_q - WIDTH'(1)));
`endif

    always_comb begin
        ring_d = rotated;
        if (load)
            ring_d = seed;
`ifdef RING_COUNTER_SELFCORRECT_EN
        else if (multi_hot)
            ring_d = WIDTH'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ring_q <= '0;
        else
            ring_q <= ring_d;
    end

    assign q = ring_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_counter.sv
// tb_ring_counter: directed stimulus with a queued-expectation scoreboard for ring_counter (WIDTH=4).
`default_nettype none

module tb_ring_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic         in_bit;
    logic [W-1:0] q;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ring_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .in   (in_bit),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (q !== e.exp) begin
                errors++;
                $display("FAIL %s: q=%b expected %b", e.name, q, e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic ld, input logic d,
                        input logic [W-1:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        rst    = r;
        load   = ld;
        in_bit = d;
        x.exp  = e;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic check_now(input logic [W-1:0] e, input string nm);
        checks++;
        if (q !== e) begin
            errors++;
            $display("FAIL %s: q=%b expected %b", nm, q, e);
        end
    endtask

    initial begin
        exp_t x;
        int   waited;
        rst    = 1'b0;
        load   = 1'b0;
        in_bit = 1'b0;
        #2;
        check_now(4'b0000, "reset_initial");

        // Reset dominates a pending load; release with load held captures the seed.
        step(1'b0, 1'b1, 1'b1, 4'b0000, "rst_prio_0");
        step(1'b0, 1'b1, 1'b1, 4'b0000, "rst_prio_1");
        step(1'b1, 1'b1, 1'b1, 4'b0001, "rst_release_load");

        step(1'b1, 1'b0, 1'b0, 4'b0010, "rot_1");
        step(1'b1, 1'b0, 1'b1, 4'b0100, "rot_2_in_ignored");
        step(1'b1, 1'b0, 1'b0, 4'b1000, "rot_3");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "rot_wrap");
        step(1'b1, 1'b0, 1'b0, 4'b0010, "rot_5");
        step(1'b1, 1'b0, 1'b0, 4'b0100, "rot_6");

        // Reload from 0100 restarts at bit 0.
        step(1'b1, 1'b1, 1'b1, 4'b0001, "reload");
        step(1'b1, 1'b0, 1'b0, 4'b0010, "reload_r1");
        step(1'b1, 1'b0, 1'b0, 4'b0100, "reload_r2");
        step(1'b1, 1'b0, 1'b0, 4'b1000, "reload_r3");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "reload_r4");
        step(1'b1, 1'b0, 1'b0, 4'b0010, "reload_r5");

        // Load zero from 0010 clears; all-zero state rotates to itself.
        step(1'b1, 1'b1, 1'b0, 4'b0000, "load_zero");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, (i % 2 == 0), 4'b0000, "zero_hold");

        step(1'b1, 1'b1, 1'b1, 4'b0001, "load_a");
        step(1'b1, 1'b0, 1'b0, 4'b0010, "load_a_r1");
        step(1'b1, 1'b0, 1'b0, 4'b0100, "load_a_r2");

        // Asynchronous reset mid-cycle with q=0100.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_now(4'b0000, "async_reset");
        step(1'b0, 1'b1, 1'b1, 4'b0000, "rst_hold_0");
        step(1'b0, 1'b0, 1'b1, 4'b0000, "rst_hold_1");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b1, 4'b0000, "post_rst_zero");

        // Multi-hot state injected directly into the ring register.
        step(1'b1, 1'b1, 1'b1, 4'b0001, "load_b");
        @(negedge clk);
        load   = 1'b0;
        in_bit = 1'b0;
        force dut.ring_q = 4'b0110;
        #1;
        release dut.ring_q;
`ifdef RING_COUNTER_SELFCORRECT_EN
        x.exp = 4'b0001;
`else
        x.exp = 4'b1100;
`endif
        x.name = "multi_hot_step";
        exp_q.push_back(x);
`ifdef RING_COUNTER_SELFCORRECT_EN
        step(1'b1, 1'b0, 1'b0, 4'b0010, "multi_hot_r1");
        step(1'b1, 1'b0, 1'b0, 4'b0100, "multi_hot_r2");
`else
        step(1'b1, 1'b0, 1'b0, 4'b1001, "multi_hot_r1");
        step(1'b1, 1'b0, 1'b0, 4'b0011, "multi_hot_r2");
`endif

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
